// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUop codes,
// mux select codes, branch types and the main FSM state encoding.
package mips_ctrl_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUop codes consumed by alu_control
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   // BranchType codes; the datapath evaluates the condition
   localparam logic [1:0] BT_BEQ  = 2'b00;
   localparam logic [1:0] BT_BNE  = 2'b01;
   localparam logic [1:0] BT_BGTZ = 2'b10;

   // ALUSrcB select codes
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource select codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Main FSM state encoding; 13..15 are unused and recover to IDLE
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_RTYPE_EX = 4'd7,
      S_RTYPE_WB = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   // States that issue a memory access and may stall on mem_ready
   function automatic logic is_mem_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory access and flags a timeout
// in the cycle the count reaches the limit while memory is still not ready.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic mem_ready,
   input  logic clear,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(MEM_WAIT_MAX);

   logic [7:0] wait_cnt_reg;

   // A ready in the limit cycle wins, so the timeout needs mem_ready low
   assign timeout = active && !mem_ready && (wait_cnt_reg == LIMIT);

   // Restart on any state change; count only stalled cycles of a memory state
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wait_cnt_reg <= 8'd0;
      end else if (active && !mem_ready) begin
         wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. Moore decode of the state
// register, except IRWrite/PCWrite in FETCH which wait for mem_ready.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] ALUop,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] BranchType,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   state_t     state_reg;
   state_t     state_next;
   logic       is_store_reg;
   logic [1:0] branch_type_reg;
   logic       timeout;

   assign state       = state_reg;
   assign mem_timeout = timeout;

   mem_wait_timer #(
      .MEM_WAIT_MAX(MEM_WAIT_MAX)
   ) u_wait (
      .clk       (clk),
      .reset     (reset),
      .active    (is_mem_wait_state(state_reg)),
      .mem_ready (mem_ready),
      .clear     (state_next != state_reg),
      .timeout   (timeout)
   );

   // State register; opcode details needed after DECODE are latched there,
   // since opcode is only guaranteed valid in DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         is_store_reg    <= 1'b0;
         branch_type_reg <= BT_BEQ;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE) begin
            is_store_reg <= (opcode == OP_SW);
            case (opcode)
               OP_BNE:  branch_type_reg <= BT_BNE;
               OP_BGTZ: branch_type_reg <= BT_BGTZ;
               default: branch_type_reg <= BT_BEQ;
            endcase
         end
      end
   end

   // Next-state and control decode; everything defaults to inactive/zero
   always_comb begin
      state_next  = state_reg;
      ALUop       = ALUOP_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSource    = PCSRC_ALU;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchType  = BT_BEQ;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            if (mem_ready) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               state_next = S_DECODE;
            end else if (timeout) begin
               state_next = S_IDLE;
            end
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH2;
            case (opcode)
               OP_RTYPE:                 state_next = S_RTYPE_EX;
               OP_LW, OP_SW:             state_next = S_MEMADR;
               OP_BEQ, OP_BNE, OP_BGTZ:  state_next = S_BRANCH;
               OP_ADDI:                  state_next = S_ADDI_EX;
               OP_J:                     state_next = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_IMM;
            state_next = is_store_reg ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_next = S_MEMWB;
            end else if (timeout) begin
               state_next = S_IDLE;
            end
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               state_next = S_FETCH;
            end else if (timeout) begin
               state_next = S_IDLE;
            end
         end
         S_RTYPE_EX: begin
            ALUSrcA    = 1'b1;
            ALUop      = ALUOP_FUNC;
            state_next = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUop       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            BranchType  = branch_type_reg;
            state_next  = S_FETCH;
         end
         S_ADDI_EX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_IMM;
            state_next = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite   = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            state_next = S_FETCH;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction sequences followed by
// random opcodes, mem_ready stalls and resets, checked cycle by cycle against
// an instruction-level reference model.
module tb_multicycle_control;

   localparam int WMAX = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic [1:0] ALUop, ALUSrcB, PCSource, BranchType;
   logic       ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, RegDst, RegWrite, illegal_op, mem_timeout;
   logic [3:0] state;
   logic [19:0] dut_word;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT_MAX(WMAX)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchType(BranchType),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
   );

   assign dut_word = {ALUop, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond,
                      BranchType, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, illegal_op, mem_timeout};

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   // Reference model: current step, stall count, remaining steps of the instruction
   int  cur = 0;
   int  wait_n = 0;
   int  btype = 0;
   int  pending[$];
   bit  model_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected control word for one cycle, written from the per-step control table
   function automatic logic [19:0] exp_word(input int st, input logic rdy, input logic [5:0] op);
      logic [1:0] aluop = 0, srcb = 0, pcsrc = 0, bt = 0;
      logic srca = 0, pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rdst = 0, rw = 0, ill = 0, tmo = 0;
      logic stall_limit;
      stall_limit = !rdy && (wait_n == WMAX);
      case (st)
         1:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; tmo = stall_limit; end
         2:  begin srcb = 2'b11;
                   ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h07, 6'h08, 6'h02}); end
         3:  begin srca = 1; srcb = 2'b10; end
         4:  begin mrd = 1; iord = 1; tmo = stall_limit; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mwr = 1; iord = 1; tmo = stall_limit; end
         7:  begin srca = 1; aluop = 2'b10; end
         8:  begin rw = 1; rdst = 1; end
         9:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; bt = 2'(btype); end
         10: begin srca = 1; srcb = 2'b10; end
         11: begin rw = 1; end
         12: begin pcw = 1; pcsrc = 2'b10; end
         default: ;
      endcase
      return {aluop, srca, srcb, pcsrc, pcw, pcwc, bt, iord, mrd, mwr, irw, m2r, rdst, rw, ill, tmo};
   endfunction

   // Advance the model by one clock: instruction paths are expanded at decode
   task automatic advance(input logic rdy, input logic [5:0] op);
      if (cur == 0) begin
         cur = 1;
      end else if ((cur == 1 || cur == 4 || cur == 6) && !rdy) begin
         if (wait_n == WMAX) begin
            cur = 0; wait_n = 0; pending.delete();
         end else begin
            wait_n++;
         end
      end else if (cur == 1) begin
         wait_n = 0; cur = 2;
      end else if (cur == 2) begin
         pending.delete();
         case (op)
            6'h00: begin pending.push_back(7); pending.push_back(8); end
            6'h23: begin pending.push_back(3); pending.push_back(4); pending.push_back(5); end
            6'h2b: begin pending.push_back(3); pending.push_back(6); end
            6'h04: begin pending.push_back(9); btype = 0; end
            6'h05: begin pending.push_back(9); btype = 1; end
            6'h07: begin pending.push_back(9); btype = 2; end
            6'h08: begin pending.push_back(10); pending.push_back(11); end
            6'h02: pending.push_back(12);
            default: ;
         endcase
         cur = (pending.size() > 0) ? pending.pop_front() : 1;
      end else begin
         wait_n = 0;
         cur = (pending.size() > 0) ? pending.pop_front() : 1;
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, check, then step the model
   task automatic cycle(input logic rdy, input logic [5:0] op, input logic rst);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      reset     = rst;
      #1;
      if (model_valid) begin
         check($sformatf("state(exp %0d)", cur), 32'(state), 32'(cur));
         check($sformatf("ctrl@st%0d rdy%0d op%0h", cur, rdy, op), 32'(dut_word), 32'(exp_word(cur, rdy, op)));
      end
      if (rst) begin
         cur = 0; wait_n = 0; pending.delete(); model_valid = 1'b1;
      end else begin
         advance(rdy, op);
      end
   endtask

   logic [5:0] op_tab [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h07, 6'h08, 6'h02, 6'h3f};

   initial begin
      int stall_left;
      logic rdy;
      logic [5:0] op;

      // Reset for two cycles
      cycle(0, 6'h00, 1);
      cycle(0, 6'h00, 1);

      // R-type: IDLE, FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH
      repeat (6) cycle(1, 6'h00, 0);

      // lw with three stalls in MEMRD; opcode garbage outside DECODE
      cycle(1, 6'h23, 0);
      cycle(1, 6'h2b, 0);
      repeat (3) cycle(0, 6'h3f, 0);
      cycle(1, 6'h3f, 0);   // ready in the limit cycle wins
      cycle(1, 6'h00, 0);   // MEMWB
      cycle(1, 6'h00, 0);   // FETCH

      // bne
      cycle(1, 6'h05, 0);
      cycle(1, 6'h04, 0);
      cycle(1, 6'h00, 0);

      // illegal opcode, then FETCH timeout, IDLE, refetch
      cycle(1, 6'h3f, 0);
      repeat (4) cycle(0, 6'h00, 0);
      cycle(0, 6'h00, 0);
      cycle(1, 6'h00, 0);

      // lw timing out in MEMRD
      cycle(1, 6'h23, 0);
      cycle(1, 6'h23, 0);
      repeat (4) cycle(0, 6'h23, 0);
      cycle(1, 6'h00, 0);   // IDLE
      cycle(1, 6'h00, 0);   // FETCH

      // sw, reset while in MEMWR, recovery
      cycle(1, 6'h2b, 0);
      cycle(1, 6'h00, 0);
      cycle(0, 6'h00, 0);   // MEMWR stalled
      cycle(0, 6'h00, 1);   // reset in MEMWR: MemWrite still visible
      cycle(1, 6'h00, 0);   // IDLE, all zero
      cycle(1, 6'h08, 0);   // FETCH
      cycle(1, 6'h08, 0);   // DECODE addi
      cycle(1, 6'h02, 0);
      cycle(1, 6'h02, 0);

      // Random opcodes, stall bursts and occasional resets
      stall_left = 0;
      for (int i = 0; i < 600; i++) begin
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) stall_left = $urandom_range(2, 6);
         end
         if ($urandom_range(0, 5) == 0) op = 6'($urandom);
         else op = op_tab[$urandom_range(0, 8)];
         cycle(rdy, op, ($urandom_range(0, 79) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath: decodes the 6-bit opcode across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps and drives datapath enables, mux selects, and the 2-bit `ALUop` consumed by `alu_control`. It is the producing end of the `ALUop` interface:

- `00` add: addi, lw/sw address, PC increment.
- `01` sub: beq, bne, bgtz compare.
- `10` R-type: `alu_control` decodes `func`.

It sits between the instruction register and the datapath and adds a memory wait-state handshake with timeout.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive wait cycles tolerated in any memory state before timeout. Range 1..255.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: `IR[31:26]`, valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `ALUop` out 2: to `alu_control`.
- `ALUSrcA` out 1: 0 = PC, 1 = register A.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: conditional PC load.
- `BranchType` out 2: 00 = beq, 01 = bne, 10 = bgtz.
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: write-back source is MDR.
- `RegDst` out 1: destination register is rd.
- `RegWrite` out 1: register file write enable.
- `illegal_op` out 1: one-cycle pulse for an unsupported opcode.
- `mem_timeout` out 1: one-cycle pulse when the wait limit is exceeded.
- `state` out 4: current state, for debug.

## Operation
- State encoding (4 bits):
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - RTYPE_EX=7, RTYPE_WB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12
  - Encodings 13–15: next state is IDLE.
- Reset:
  - Synchronous, active-high; next state is IDLE.
  - In IDLE every output is 0 and `state`=0.
  - IDLE goes to FETCH unconditionally on the next cycle.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite assert only in a cycle where `mem_ready`=1; the state then advances to DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUop=00 to precompute the branch target.
  - Dispatch on `opcode`:
    - 000000 → RTYPE_EX
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100, 000101, 000111 → BRANCH
    - 001000 → ADDI_EX
    - 000010 → JUMP
    - anything else → FETCH, with `illegal_op`=1 in the DECODE cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1; waits on `mem_ready`, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; goes to FETCH.
- MEMWR: MemWrite=1, IorD=1; waits on `mem_ready`, then goes to FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUop=10; goes to RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
  - BranchType is 00/01/10 for beq/bne/bgtz; the datapath evaluates the condition.
  - Goes to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUop=00; goes to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; goes to FETCH.
- JUMP: PCWrite=1, PCSource=10; goes to FETCH.
- Default values for any output a state does not drive: all enables 0, all selects 0.

## Timing
- All outputs are Moore decodes of the registered state. The only exceptions are IRWrite/PCWrite in FETCH, which are gated by `mem_ready`.
- Wait counter (`wait_cnt`, 8 bits):
  - Cleared on every state change and on reset.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
  - When `wait_cnt`==MEM_WAIT_MAX and `mem_ready`=0: pulse `mem_timeout` that cycle, next state is IDLE, and no write enables assert in that cycle.
  - `mem_ready`=1 in the limit cycle wins: normal advance, no timeout.
- Latencies with `mem_ready` held at 1:
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq/bne/bgtz, j: 3 cycles.
  - Illegal opcode: 2 cycles (FETCH, DECODE).
- Reset asserted mid-instruction: state is IDLE on the next edge. Any write enable already visible in the reset cycle completes; no further enables follow.
- `opcode` is sampled only in DECODE; changes in other states are ignored.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_BGTZ`, `OP_ADDI`, `OP_J`)
  - `ALUop` constants (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNC`), which `alu_control` also uses
  - the state encoding and the BranchType codes.
- One natural sub-module: `mem_wait_timer` (counter plus compare, emits the timeout pulse). The FSM stays in one module.

## Test plan
- Reset for 2 cycles, release, `mem_ready`=1, `opcode`=000000 → `state` sequence 0,1,2,7,8,1; `ALUop`=10 in RTYPE_EX; RegWrite=1 and RegDst=1 only in RTYPE_WB.
- `opcode`=100011 with `mem_ready` low for 3 cycles in MEMRD → stays in state 4 for 4 cycles, then 5; MemtoReg=1 and RegWrite=1 in MEMWB; lw total is 8 cycles.
- `opcode`=000101 → BRANCH shows `ALUop`=01, BranchType=01, PCWriteCond=1; back to FETCH after 3 cycles.
- `opcode`=111111 → `illegal_op` pulses in DECODE; next state is 1; RegWrite, MemWrite and PCWrite never assert.
- MEM_WAIT_MAX=3, `mem_ready` held 0 in FETCH → `mem_timeout` on the 4th FETCH cycle, then IDLE; IRWrite never asserted.
- Reset asserted in MEMWR → next state IDLE with all outputs 0; recovery fetch from state 1 on the following cycle.
